// File: rtl/cocotb_array_pkg.sv
// Shared types and constants for the multi-dimensional array path:
// element and frame typedefs, frame length, assembler state encoding.
package cocotb_array_pkg;

  localparam int ELEM_W    = 3;
  localparam int ARR_DIM   = 3;
  localparam int FRAME_LEN = ARR_DIM * ARR_DIM * ARR_DIM;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [ARR_DIM-1:0][ARR_DIM-1:0][ARR_DIM-1:0] arr3d_packed_t;
  typedef elem_t arr3d_unpacked_t [ARR_DIM-1:0][ARR_DIM-1:0][ARR_DIM-1:0];

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } asm_state_t;

  // Index counter width: clog2 of the extent, never narrower than one bit.
  function automatic int idx_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/cocotb_array_idx_counter.sv
// Three cascaded wrap counters (k innermost, then j, then i) walking a
// DIM x DIM x DIM frame; flags the final index of the frame.
module cocotb_array_idx_counter
  import cocotb_array_pkg::*;
#(
  parameter int DIM = 3,
  parameter int CW  = idx_w(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] idx_i,
  output logic [CW-1:0] idx_j,
  output logic [CW-1:0] idx_k,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(DIM - 1);

  // Clear wins over increment so a frame boundary always restarts at [0][0][0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_i <= '0;
      idx_j <= '0;
      idx_k <= '0;
    end else if (clr) begin
      idx_i <= '0;
      idx_j <= '0;
      idx_k <= '0;
    end else if (inc) begin
      if (idx_k == MAX) begin
        idx_k <= '0;
        if (idx_j == MAX) begin
          idx_j <= '0;
          idx_i <= (idx_i == MAX) ? '0 : idx_i + CW'(1);
        end else begin
          idx_j <= idx_j + CW'(1);
        end
      end else begin
        idx_k <= idx_k + CW'(1);
      end
    end
  end

  assign last = (idx_i == MAX) && (idx_j == MAX) && (idx_k == MAX);

endmodule

// File: rtl/cocotb_array_assembler.sv
// Assembles a serial element stream into a DIM^3 frame and holds it, in
// packed and unpacked form, until the consumer accepts it.
module cocotb_array_assembler
  import cocotb_array_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int DIM    = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [DATA_W-1:0]                             s_data,
  input  logic                                          s_last,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [DIM-1:0][DIM-1:0][DIM-1:0][DATA_W-1:0]  out_arr_packed,
  output logic [DATA_W-1:0]                             out_arr_unpacked [DIM-1:0][DIM-1:0][DIM-1:0],
  output logic                                          len_err
);

  localparam int CW = idx_w(DIM);

  asm_state_t    state_q, state_d;
  logic [CW-1:0] idx_i, idx_j, idx_k;
  logic          idx_last;
  logic          beat;
  logic          cnt_inc, cnt_clr;
  logic          len_err_d;

  assign s_ready = (state_q == ST_FILL);
  assign m_valid = (state_q == ST_HOLD);
  assign beat    = s_valid & s_ready;

  cocotb_array_idx_counter #(
    .DIM (DIM),
    .CW  (CW)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .idx_i (idx_i),
    .idx_j (idx_j),
    .idx_k (idx_k),
    .last  (idx_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      len_err <= 1'b0;
    end else begin
      state_q <= state_d;
      len_err <= len_err_d;
    end
  end

  // A frame ends on the final index (complete, length error if s_last is
  // missing) or on an early s_last (discarded, counters restart).
  always_comb begin
    state_d   = state_q;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    len_err_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (beat) begin
          if (idx_last) begin
            state_d   = ST_HOLD;
            cnt_clr   = 1'b1;
            len_err_d = ~s_last;
          end else if (s_last) begin
            cnt_clr   = 1'b1;
            len_err_d = 1'b1;
          end else begin
            cnt_inc   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (m_ready) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Frame storage lives in the unpacked output; the packed view is pure wiring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DIM; a++)
        for (int b = 0; b < DIM; b++)
          for (int c = 0; c < DIM; c++)
            out_arr_unpacked[a][b][c] <= '0;
    end else if (beat) begin
      out_arr_unpacked[idx_i][idx_j][idx_k] <= s_data;
    end
  end

  for (genvar gi = 0; gi < DIM; gi++) begin : g_i
    for (genvar gj = 0; gj < DIM; gj++) begin : g_j
      for (genvar gk = 0; gk < DIM; gk++) begin : g_k
        assign out_arr_packed[gi][gj][gk] = out_arr_unpacked[gi][gj][gk];
      end
    end
  end

endmodule

// File: doc/cocotb_array_assembler.md
# cocotb_array_assembler

Receives a serial stream of DATA_W-bit elements over a valid/ready handshake and assembles each frame of DIM³ elements into a 3-D array. The array is presented in two forms at once: a fully packed vector and a fully unpacked array. A valid/ready handshake holds each completed frame until the consumer accepts it. The block is the receive end of the multi-dimensional array path and feeds the array passthrough bench with real, sequenced data.

## Interface
- DATA_W, default 3: element width in bits.
- DIM, default 3: extent of every dimension; one frame is DIM³ elements (27 by default).
- clk  input  1  the single clock, rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- s_valid  input  1  input element valid.
- s_ready  output  1  block can accept an element.
- s_data  input  DATA_W  element value.
- s_last  input  1  marks the final element of a frame.
- m_valid  output  1  assembled frame available.
- m_ready  input  1  consumer accepts the frame.
- out_arr_packed  output  [DIM-1:0][DIM-1:0][DIM-1:0][DATA_W-1:0]  frame, fully packed.
- out_arr_unpacked  output  [DATA_W-1:0] x [DIM-1:0][DIM-1:0][DIM-1:0] unpacked  the same frame, fully unpacked.
- len_err  output  1  one-cycle pulse when a frame length violation is detected.

## Operation
- The block has two states.
  - FILL: s_ready=1, m_valid=0.
  - HOLD: s_ready=0, m_valid=1.
- Beat accepted = s_valid & s_ready.
- Index counters i, j, k each run 0..DIM-1. k is innermost and increments on every accepted beat; it wraps to 0 and carries into j, which carries into i.
- An accepted beat writes element [i][j][k] in both output forms. Both forms always carry identical content.
- Normal completion (FILL→HOLD):
  - The beat at [DIM-1][DIM-1][DIM-1] is accepted with s_last=1.
  - Counters clear to 0.
- Missing s_last:
  - The final-index beat is accepted with s_last=0.
  - The frame still completes and the block enters HOLD.
  - len_err pulses.
- Early s_last:
  - A beat is accepted with s_last=1 at any earlier index.
  - That element is written, then the frame is discarded: counters clear to 0, the state stays FILL, and len_err pulses.
  - Array contents are not cleared, but they are never presented until a full frame overwrites them.
- HOLD→FILL: on m_valid & m_ready.
- Array contents hold stable throughout HOLD and are not modified until the next accepted beat.
- In HOLD, s_data, s_valid and s_last are ignored.
- s_data is captured as-is; there is no arithmetic on the data path.
- Counter width is clog2(DIM), minimum 1 bit.

## Timing
- On reset assertion (asynchronous), regardless of state or mid-frame position:
  - State = FILL, all counters = 0.
  - s_ready=1, m_valid=0, len_err=0.
  - out_arr_packed and out_arr_unpacked = all zeros.
- First cycle after reset release: s_ready=1.
- Latency:
  - The final beat is accepted at edge N.
  - m_valid=1 and the full array are visible after edge N.
  - s_ready=0 in the same cycle.
- Release:
  - m_ready=1 while m_valid=1 at edge M.
  - m_valid=0 and s_ready=1 after edge M.
  - The earliest next accepted beat is edge M+1.
  - There is no same-cycle pass-through between consumer and producer.
- Minimum frame period: DIM³+1 cycles.
- len_err is registered and high for exactly the one cycle after the offending beat's edge.
- m_ready asserted while m_valid=0 has no effect.
- s_ready is a registered/state-derived output with no combinational path from m_ready.

## Structure
- The frame array typedefs belong in the shared package cocotb_array_pkg, next to the existing array types, so benches and passthrough tops share them:
  - elem_t
  - arr3d_packed_t
  - arr3d_unpacked_t
- The frame-length constant DIM*DIM*DIM also belongs in cocotb_array_pkg.
- One sub-module is natural: cocotb_array_idx_counter. It holds the three cascaded wrap counters and provides a "last index" flag; it takes increment and clear inputs.
- The top module holds the FSM, the storage, and the packed/unpacked output mapping.

## Test plan
- Reset then idle:
  - Stimulus: hold rst=1, then release.
  - Required: s_ready=1, m_valid=0, len_err=0, both arrays are zero.
- Full frame, continuous valid:
  - Stimulus: element n = n mod 8, s_last on beat 27.
  - Required: m_valid rises 1 cycle after beat 27.
  - Required: out_arr_unpacked[i][j][k] = (9i+3j+k) mod 8, and out_arr_packed matches.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles after completion while s_valid stays 1.
  - Required: s_ready=0 and arrays are stable for all 10 cycles.
  - Stimulus: m_ready=1 for one cycle.
  - Required: s_ready=1 the next cycle, and the next frame's first beat lands at [0][0][0].
- Early s_last:
  - Stimulus: s_last on beat 5.
  - Required: len_err pulses once, m_valid stays 0.
  - Stimulus: a following full 27-beat frame.
  - Required: it completes normally with correct contents.
- Missing s_last:
  - Stimulus: 27 beats with s_last=0.
  - Required: m_valid=1 and len_err pulses in the same cycle.
- Reset mid-operation:
  - Stimulus: assert rst after 13 beats, and again separately during HOLD.
  - Required: immediately m_valid=0, s_ready=1, arrays zero.
  - Required: the next 27 beats form a correct frame from index [0][0][0].
